// File: rtl/vpb_ctrl_seq_pkg.sv
// Shared definitions for the VPB board controller: GS4911/GS4915 control-word
// bit positions, sequencer state encodings and control-word pack helpers.
package vpb_ctrl_pkg;

    // GS4911 word: {VID_STD0..VID_STD5, GENLOCKn}; VID_STD sits bit-reversed above GENLOCKn
    localparam int G11_GENLOCKN  = 0;
    localparam int G11_STD0_BIT  = 6;

    // GS4915 word: {SKEW_EN,DOUBLE,FCTRL1,FCTRL0,AUTOBYPASS,BYPASS,IPSEL,RESETn}
    localparam int G15_RESETN     = 0;
    localparam int G15_IPSEL      = 1;
    localparam int G15_BYPASS     = 2;
    localparam int G15_AUTOBYPASS = 3;
    localparam int G15_FCTRL0     = 4;
    localparam int G15_FCTRL1     = 5;
    localparam int G15_DOUBLE     = 6;
    localparam int G15_SKEW_EN    = 7;

    typedef enum logic [1:0] {
        G_RST_HOLD  = 2'd0,
        G_LOCK_WAIT = 2'd1,
        G_DRV_REL   = 2'd2,
        G_RUN       = 2'd3
    } gstate_t;

    typedef enum logic [1:0] {
        C_IDLE     = 2'd0,
        C_MUTE_PRE = 2'd1,
        C_SWITCH   = 2'd2,
        C_SETTLE   = 2'd3
    } cstate_t;

    // GENLOCKn is tied high (free-run); VID_STD[0] lands in the MSB
    function automatic logic [6:0] gs4911_word(input logic [5:0] vid_std);
        logic [6:0] w;
        w = '0;
        w[G11_GENLOCKN] = 1'b1;
        for (int i = 0; i < 6; i++) w[G11_STD0_BIT - i] = vid_std[i];
        return w;
    endfunction

    // Passthrough sets DOUBLE and IPSEL together; skew/fctrl/bypass stay off
    function automatic logic [7:0] gs4915_word(input logic passthru, input logic resetn);
        logic [7:0] w;
        w = '0;
        w[G15_DOUBLE] = passthru;
        w[G15_IPSEL]  = passthru;
        w[G15_RESETN] = resetn;
        return w;
    endfunction

endpackage

// File: rtl/vpb_ctrl_seq_if.sv
// Board-side bundle of the VPB controller: config switches, lock input,
// per-channel requests and all device control outputs.
interface vpb_ctrl_seq_if #(
    parameter int NUM_CH = 2
);
    logic              cfg_frac_frate;
    logic              cfg_passthru;
    logic              tx_lock;
    logic [NUM_CH-1:0] ch_sd_req;
    logic [NUM_CH-1:0] ch_en_req;
    logic [NUM_CH-1:0] ch_bypass;

    logic [6:0]        TX_GS4911_CTRL;
    logic [6:0]        RX_GS4911_CTRL;
    logic [7:0]        TX_GS4915_CTRL;
    logic [7:0]        RX_GS4915_CTRL;
    logic              SDI_DRV_RSTI;
    logic [NUM_CH-1:0] SD_HD;
    logic [NUM_CH-1:0] DISABLE;
    logic [NUM_CH-1:0] MUTE;
    logic [NUM_CH-1:0] BYPASS;
    logic              ready;
    logic              lock_err;
    logic [NUM_CH-1:0] ch_busy;

    // controller side
    modport slave (
        input  cfg_frac_frate, cfg_passthru, tx_lock, ch_sd_req, ch_en_req, ch_bypass,
        output TX_GS4911_CTRL, RX_GS4911_CTRL, TX_GS4915_CTRL, RX_GS4915_CTRL,
               SDI_DRV_RSTI, SD_HD, DISABLE, MUTE, BYPASS, ready, lock_err, ch_busy
    );

    // board / stimulus side
    modport master (
        output cfg_frac_frate, cfg_passthru, tx_lock, ch_sd_req, ch_en_req, ch_bypass,
        input  TX_GS4911_CTRL, RX_GS4911_CTRL, TX_GS4915_CTRL, RX_GS4915_CTRL,
               SDI_DRV_RSTI, SD_HD, DISABLE, MUTE, BYPASS, ready, lock_err, ch_busy
    );
endinterface

// File: rtl/vpb_ch_seq.sv
// One SDI channel sequencer: mute, wait, switch rate/enable, settle, unmute.
// A forced pass after every run-up guarantees the channel only unmutes
// through a complete settle sequence.
module vpb_ch_seq
    import vpb_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 256
) (
    input  logic lclk,
    input  logic rst_n,
    input  logic run,
    input  logic sd_req,
    input  logic en_req,
    output logic sd_hd,
    output logic en,
    output logic mute,
    output logic busy
);
    localparam int              CW          = $clog2(SETTLE_CYC) + 1;
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYC - 1);

    cstate_t       state;
    logic [CW-1:0] cnt;
    logic          resync;

    // channel FSM with registered outputs; losing run forces IDLE + mute
    always_ff @(posedge lclk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= C_IDLE;
            cnt    <= '0;
            sd_hd  <= 1'b0;
            en     <= 1'b0;
            mute   <= 1'b1;
            busy   <= 1'b0;
            resync <= 1'b1;
        end else if (!run) begin
            state  <= C_IDLE;
            cnt    <= '0;
            mute   <= 1'b1;
            busy   <= 1'b0;
            resync <= 1'b1;
        end else begin
            case (state)
                C_IDLE: begin
                    if (resync || (sd_req != sd_hd) || (en_req != en)) begin
                        state  <= C_MUTE_PRE;
                        cnt    <= SETTLE_LOAD;
                        mute   <= 1'b1;
                        busy   <= 1'b1;
                        resync <= 1'b0;
                    end
                end
                C_MUTE_PRE: begin
                    if (cnt == '0) state <= C_SWITCH;
                    else           cnt   <= cnt - 1'b1;
                end
                C_SWITCH: begin
                    sd_hd <= sd_req;
                    en    <= en_req;
                    state <= C_SETTLE;
                    cnt   <= SETTLE_LOAD;
                end
                C_SETTLE: begin
                    if (cnt == '0) begin
                        state <= C_IDLE;
                        mute  <= ~en;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vpb_ctrl_seq.sv
// VPB board controller top: input synchronisers, global power-up / lock
// sequencer, GS4911/GS4915 code decode and per-channel sequencers.
module vpb_ctrl_seq
    import vpb_ctrl_pkg::*;
#(
    parameter int         NUM_CH        = 2,
    parameter int         RST_HOLD_CYC  = 1024,
    parameter int         LOCK_WAIT_CYC = 65536,
    parameter int         SETTLE_CYC    = 256,
    parameter logic [5:0] VID_STD_INT   = 6'd21,
    parameter logic [5:0] VID_STD_FRAC  = 6'd22
) (
    input  logic           lclk,
    input  logic           rst_n,
    vpb_ctrl_seq_if.slave  bus
);
    localparam int            MAX_A     = (RST_HOLD_CYC > LOCK_WAIT_CYC) ? RST_HOLD_CYC : LOCK_WAIT_CYC;
    localparam int            MAX_CYC   = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
    localparam int            CW        = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] RST_LOAD  = CW'(RST_HOLD_CYC - 1);
    localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_WAIT_CYC - 1);
    localparam logic [CW-1:0] SET_LOAD  = CW'(SETTLE_CYC - 1);

    logic frac_meta, frac_s, pass_meta, pass_s, lock_meta, lock_s;

    // 2-flop synchronisers; reset values match the frozen config so
    // release does not trigger a spurious re-sequence
    always_ff @(posedge lclk or negedge rst_n) begin
        if (!rst_n) begin
            frac_meta <= 1'b0;  frac_s <= 1'b0;
            pass_meta <= 1'b1;  pass_s <= 1'b1;
            lock_meta <= 1'b0;  lock_s <= 1'b0;
        end else begin
            frac_meta <= bus.cfg_frac_frate;  frac_s <= frac_meta;
            pass_meta <= bus.cfg_passthru;    pass_s <= pass_meta;
            lock_meta <= bus.tx_lock;         lock_s <= lock_meta;
        end
    end

    gstate_t       gstate;
    logic [CW-1:0] gcnt;
    logic          frac_q, pass_q, resetn_q, drv_q, ready_q, lock_err_q;
    logic [5:0]    vid_q;

    // config change restarts the whole sequence; lock loss drops out of RUN
    logic cfg_chg, lock_loss, run;
    assign cfg_chg   = (frac_s != frac_q) || (pass_s != pass_q);
    assign lock_loss = (gstate == G_RUN) && !lock_s;
    // channels are released only while RUN holds this cycle and next
    assign run       = ready_q && !cfg_chg && !lock_loss;

    // global sequencer with one shared down-counter and registered outputs
    always_ff @(posedge lclk or negedge rst_n) begin
        if (!rst_n) begin
            gstate     <= G_RST_HOLD;
            gcnt       <= RST_LOAD;
            frac_q     <= 1'b0;
            pass_q     <= 1'b1;
            vid_q      <= VID_STD_INT;
            resetn_q   <= 1'b0;
            drv_q      <= 1'b0;
            ready_q    <= 1'b0;
            lock_err_q <= 1'b0;
        end else if (cfg_chg) begin
            gstate   <= G_RST_HOLD;
            gcnt     <= RST_LOAD;
            frac_q   <= frac_s;
            pass_q   <= pass_s;
            vid_q    <= frac_s ? VID_STD_FRAC : VID_STD_INT;
            resetn_q <= 1'b0;
            drv_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            case (gstate)
                G_RST_HOLD: begin
                    if (gcnt == '0) begin
                        gstate   <= G_LOCK_WAIT;
                        gcnt     <= LOCK_LOAD;
                        resetn_q <= 1'b1;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                G_LOCK_WAIT: begin
                    if (lock_s || gcnt == '0) begin
                        if (!lock_s) lock_err_q <= 1'b1;
                        gstate <= G_DRV_REL;
                        gcnt   <= SET_LOAD;
                        drv_q  <= 1'b1;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                G_DRV_REL: begin
                    if (gcnt == '0) begin
                        gstate  <= G_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                G_RUN: begin
                    if (!lock_s) begin
                        lock_err_q <= 1'b1;
                        gstate     <= G_LOCK_WAIT;
                        gcnt       <= LOCK_LOAD;
                        drv_q      <= 1'b0;
                        ready_q    <= 1'b0;
                    end
                end
                default: gstate <= G_RST_HOLD;
            endcase
        end
    end

    logic [NUM_CH-1:0] bypass_q;

    // equaliser bypass is a plain registered pass-through
    always_ff @(posedge lclk or negedge rst_n) begin
        if (!rst_n) bypass_q <= '0;
        else        bypass_q <= bus.ch_bypass;
    end

    logic [NUM_CH-1:0] sd_hd_v, en_v, mute_v, busy_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        vpb_ch_seq #(.SETTLE_CYC(SETTLE_CYC)) u_ch (
            .lclk   (lclk),
            .rst_n  (rst_n),
            .run    (run),
            .sd_req (bus.ch_sd_req[i]),
            .en_req (bus.ch_en_req[i]),
            .sd_hd  (sd_hd_v[i]),
            .en     (en_v[i]),
            .mute   (mute_v[i]),
            .busy   (busy_v[i])
        );
    end

    // control words are pure bit placement of registered state
    assign bus.TX_GS4911_CTRL = gs4911_word(vid_q);
    assign bus.RX_GS4911_CTRL = gs4911_word(VID_STD_INT);
    assign bus.TX_GS4915_CTRL = gs4915_word(pass_q, resetn_q);
    assign bus.RX_GS4915_CTRL = gs4915_word(1'b0, resetn_q);
    assign bus.SDI_DRV_RSTI   = drv_q;
    assign bus.SD_HD          = sd_hd_v;
    assign bus.DISABLE        = en_v;
    assign bus.MUTE           = mute_v;
    assign bus.BYPASS         = bypass_q;
    assign bus.ready          = ready_q;
    assign bus.lock_err       = lock_err_q;
    assign bus.ch_busy        = busy_v;

endmodule

// File: tb/tb_vpb_ctrl_seq.sv
// Directed bench for vpb_ctrl_seq (NUM_CH=2, RST_HOLD=8, LOCK_WAIT=32, SETTLE=4).
// Edge numbers count rising edges since the latest reset release; outputs are
// sampled and inputs driven on the falling edge.
module tb_vpb_ctrl_seq;
    logic lclk  = 1'b0;
    logic rst_n = 1'b0;
    int   nvec  = 0;
    int   nmis  = 0;
    int   cyc   = 0;

    vpb_ctrl_seq_if #(.NUM_CH(2)) bus ();

    vpb_ctrl_seq #(
        .NUM_CH(2), .RST_HOLD_CYC(8), .LOCK_WAIT_CYC(32), .SETTLE_CYC(4)
    ) dut (
        .lclk  (lclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 lclk = ~lclk;

    // rising-edge counter since reset release
    always @(posedge lclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic to_edge(input int k);
        while (cyc < k) @(negedge lclk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tx4911"}, {1'b0, bus.TX_GS4911_CTRL}, 8'h55);
        chk({tag, "_rx4911"}, {1'b0, bus.RX_GS4911_CTRL}, 8'h55);
        chk({tag, "_tx4915"}, bus.TX_GS4915_CTRL, 8'h42);
        chk({tag, "_rx4915"}, bus.RX_GS4915_CTRL, 8'h00);
        chk({tag, "_sdi"},    {7'd0, bus.SDI_DRV_RSTI}, 8'h00);
        chk({tag, "_sdhd"},   {6'd0, bus.SD_HD}, 8'h00);
        chk({tag, "_dis"},    {6'd0, bus.DISABLE}, 8'h00);
        chk({tag, "_mute"},   {6'd0, bus.MUTE}, 8'h03);
        chk({tag, "_byp"},    {6'd0, bus.BYPASS}, 8'h00);
        chk({tag, "_ready"},  {7'd0, bus.ready}, 8'h00);
        chk({tag, "_lerr"},   {7'd0, bus.lock_err}, 8'h00);
        chk({tag, "_busy"},   {6'd0, bus.ch_busy}, 8'h00);
    endtask

    initial begin
        bus.cfg_frac_frate = 1'b0;
        bus.cfg_passthru   = 1'b1;
        bus.tx_lock        = 1'b0;
        bus.ch_sd_req      = 2'b00;
        bus.ch_en_req      = 2'b00;
        bus.ch_bypass      = 2'b00;
        repeat (2) @(negedge lclk);
        chk_reset("rst0");
        rst_n = 1'b1;

        // 1: power-up sequence with lock arriving after cycle 12
        to_edge(7);  chk("t1_resetn_low", bus.TX_GS4915_CTRL, 8'h42);
        to_edge(8);  chk("t1_resetn_rel", bus.TX_GS4915_CTRL, 8'h43);
                     chk("t1_sdi_held",   {7'd0, bus.SDI_DRV_RSTI}, 8'h00);
        to_edge(12); bus.tx_lock = 1'b1;
        to_edge(14); chk("t1_sdi_pre",    {7'd0, bus.SDI_DRV_RSTI}, 8'h00);
        to_edge(15); chk("t1_sdi_rel",    {7'd0, bus.SDI_DRV_RSTI}, 8'h01);
        to_edge(18); chk("t1_ready_pre",  {7'd0, bus.ready}, 8'h00);
        to_edge(19); chk("t1_ready",      {7'd0, bus.ready}, 8'h01);
                     chk("t1_mute",       {6'd0, bus.MUTE}, 8'h03);
                     chk("t1_lerr",       {7'd0, bus.lock_err}, 8'h00);
        to_edge(20); chk("t1_resync_busy",{6'd0, bus.ch_busy}, 8'h03);
        to_edge(29); chk("t1_resync_done",{6'd0, bus.ch_busy}, 8'h00);
                     chk("t1_mute_idle",  {6'd0, bus.MUTE}, 8'h03);

        // 3: enable ch0 as SD
        bus.ch_en_req = 2'b01;
        bus.ch_sd_req = 2'b01;
        to_edge(30); chk("t3_busy_start", {6'd0, bus.ch_busy}, 8'h01);
                     chk("t3_mute_pre",   {6'd0, bus.MUTE}, 8'h03);
        to_edge(34); chk("t3_sdhd_pre",   {6'd0, bus.SD_HD}, 8'h00);
        to_edge(35); chk("t3_sdhd_sw",    {6'd0, bus.SD_HD}, 8'h01);
                     chk("t3_dis_sw",     {6'd0, bus.DISABLE}, 8'h01);
        to_edge(38); chk("t3_mute_settle",{6'd0, bus.MUTE}, 8'h03);
                     chk("t3_busy_settle",{6'd0, bus.ch_busy}, 8'h01);
        to_edge(39); chk("t3_unmute",     {6'd0, bus.MUTE}, 8'h02);
                     chk("t3_busy_end",   {6'd0, bus.ch_busy}, 8'h00);
                     chk("t3_dis_end",    {6'd0, bus.DISABLE}, 8'h01);
        bus.ch_bypass = 2'b10;
        to_edge(40); chk("t3_bypass",     {6'd0, bus.BYPASS}, 8'h02);

        // 5: lock drop while ch0 settles after an SD->HD change
        bus.ch_sd_req = 2'b00;
        to_edge(41); chk("t5_remute",     {6'd0, bus.MUTE}, 8'h03);
        to_edge(46); chk("t5_sdhd_hd",    {6'd0, bus.SD_HD}, 8'h00);
                     chk("t5_busy_settle",{6'd0, bus.ch_busy}, 8'h01);
        bus.tx_lock = 1'b0;
        to_edge(48); chk("t5_ready_hold", {7'd0, bus.ready}, 8'h01);
                     chk("t5_lerr_pre",   {7'd0, bus.lock_err}, 8'h00);
        to_edge(49); chk("t5_ready_drop", {7'd0, bus.ready}, 8'h00);
                     chk("t5_lerr",       {7'd0, bus.lock_err}, 8'h01);
                     chk("t5_busy_abort", {6'd0, bus.ch_busy}, 8'h00);
                     chk("t5_mute_all",   {6'd0, bus.MUTE}, 8'h03);
                     chk("t5_resetn_kept",bus.TX_GS4915_CTRL, 8'h43);
        bus.tx_lock = 1'b1;
        to_edge(55); chk("t5_ready_pre",  {7'd0, bus.ready}, 8'h00);
        to_edge(56); chk("t5_ready_back", {7'd0, bus.ready}, 8'h01);
                     chk("t5_mute_run",   {6'd0, bus.MUTE}, 8'h03);
        to_edge(65); chk("t5_mute_seq",   {6'd0, bus.MUTE}, 8'h03);
                     chk("t5_busy_seq",   {6'd0, bus.ch_busy}, 8'h03);
        to_edge(66); chk("t5_unmute",     {6'd0, bus.MUTE}, 8'h02);
                     chk("t5_lerr_sticky",{7'd0, bus.lock_err}, 8'h01);

        // 4: switch to fractional frame rate in RUN
        bus.cfg_frac_frate = 1'b1;
        to_edge(68); chk("t4_ready_hold", {7'd0, bus.ready}, 8'h01);
                     chk("t4_tx4911_old", {1'b0, bus.TX_GS4911_CTRL}, 8'h55);
        to_edge(69); chk("t4_ready_drop", {7'd0, bus.ready}, 8'h00);
                     chk("t4_mute_all",   {6'd0, bus.MUTE}, 8'h03);
                     chk("t4_resetn_low", bus.TX_GS4915_CTRL, 8'h42);
                     chk("t4_tx4911_frac",{1'b0, bus.TX_GS4911_CTRL}, 8'h35);
                     chk("t4_rx4911",     {1'b0, bus.RX_GS4911_CTRL}, 8'h55);
                     chk("t4_sdi_low",    {7'd0, bus.SDI_DRV_RSTI}, 8'h00);
        to_edge(76); chk("t4_hold_end",   bus.TX_GS4915_CTRL, 8'h42);
        to_edge(77); chk("t4_resetn_rel", bus.TX_GS4915_CTRL, 8'h43);
        to_edge(81); chk("t4_ready_pre",  {7'd0, bus.ready}, 8'h00);
        to_edge(82); chk("t4_ready",      {7'd0, bus.ready}, 8'h01);

        // 6a: asynchronous reset while channels sequence, loopback selected
        to_edge(85);
        chk("t6_busy_before", {6'd0, bus.ch_busy}, 8'h03);
        bus.cfg_frac_frate = 1'b0;
        bus.cfg_passthru   = 1'b0;
        bus.tx_lock        = 1'b0;
        bus.ch_sd_req      = 2'b00;
        bus.ch_en_req      = 2'b00;
        bus.ch_bypass      = 2'b00;
        rst_n = 1'b0;
        #1;
        chk_reset("rst1");
        repeat (2) @(negedge lclk);
        rst_n = 1'b1;

        // 2 + 6a: passthru=0 re-sequences, then lock never arrives
        to_edge(2);  chk("t6_tx4915_rst", bus.TX_GS4915_CTRL, 8'h42);
        to_edge(3);  chk("t6_tx4915_lb",  bus.TX_GS4915_CTRL, 8'h00);
        to_edge(10); chk("t6_hold_end",   bus.TX_GS4915_CTRL, 8'h00);
        to_edge(11); chk("t6_resetn_rel", bus.TX_GS4915_CTRL, 8'h01);
        to_edge(42); chk("t2_lerr_pre",   {7'd0, bus.lock_err}, 8'h00);
                     chk("t2_sdi_pre",    {7'd0, bus.SDI_DRV_RSTI}, 8'h00);
        to_edge(43); chk("t2_lerr",       {7'd0, bus.lock_err}, 8'h01);
                     chk("t2_sdi_rel",    {7'd0, bus.SDI_DRV_RSTI}, 8'h01);
        to_edge(46); chk("t2_ready_pre",  {7'd0, bus.ready}, 8'h00);
        to_edge(47); chk("t2_ready",      {7'd0, bus.ready}, 8'h01);
                     chk("t6_tx4915_run", bus.TX_GS4915_CTRL, 8'h01);
                     chk("t2_mute",       {6'd0, bus.MUTE}, 8'h03);
        to_edge(48); chk("t2_ready_drop", {7'd0, bus.ready}, 8'h00);
                     chk("t2_lerr_sticky",{7'd0, bus.lock_err}, 8'h01);
        bus.tx_lock = 1'b1;
        to_edge(54); chk("t6_ready_pre",  {7'd0, bus.ready}, 8'h00);
        to_edge(55); chk("t6_ready",      {7'd0, bus.ready}, 8'h01);

        // 6b: reset pulse while channels are in MUTE_PRE
        to_edge(56); chk("t6_busy_mp",    {6'd0, bus.ch_busy}, 8'h03);
        rst_n = 1'b0;
        #1;
        chk_reset("rst2");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
